// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add controller reusing one full-adder cell (optional SERIAL_ADDER_SUB_EN)
module serial_adder_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             sub,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    // Holds the WIDTH-1 low result bits; the final bit joins them at completion.
    logic [WIDTH-2:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               bit_s;
    logic               carry_n;
    logic [WIDTH-1:0]   res_cat;
    logic [WIDTH-1:0]   b_in;
    logic               c_in;

    // The single full-adder cell shared by every bit position.
    assign bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_n = (a_sh_q[0] & b_sh_q[0]) | ((a_sh_q[0] ^ b_sh_q[0]) & carry_q);
    assign res_cat = {bit_s, res_sh_q};

`ifdef SERIAL_ADDER_SUB_EN
    logic ovf_q, ovf_d;

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
    assign ovf  = ovf_q;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // Next-state and datapath update: accept in IDLE/DONE, one bit per RUN cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b_in;
                    carry_d  = c_in;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_cat[WIDTH-1:1];
                carry_d  = carry_n;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_cat;
                    cout_d  = carry_n;
`ifdef SERIAL_ADDER_SUB_EN
                    // carry_q is the carry into the MSB during the last bit.
                    ovf_d   = carry_q ^ carry_n;
`endif
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ready, busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
    logic         ovf;
    bit           ovf_q[$];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .sub   (sub),
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive operands with start raised; the caller ticks to make the accepting edge.
    task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input bit ts);
        logic [W:0] e;
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        if (ts) e = {1'b0, ta} + {1'b0, ~tb} + (W+1)'(1);
        else    e = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        exp_q.push_back(e);
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
        if (ts) ovf_q.push_back((ta[W-1] ^ tb[W-1]) & (e[W-1] ^ ta[W-1]));
        else    ovf_q.push_back(~(ta[W-1] ^ tb[W-1]) & (e[W-1] ^ ta[W-1]));
`endif
    endtask

    task automatic accept;
        tick;
        start = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        cin = $urandom_range(0, 1);
    endtask

    // Bounded wait for done; reports ticks taken and busy cycles seen.
    task automatic wait_done(output int n, output int busy_n, output bit to);
        n = 0; busy_n = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            if (busy) busy_n++;
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        n_checks++; if (sum !== '0)    begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
`ifdef SERIAL_ADDER_SUB_EN
        n_checks++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    endtask

    task automatic test_basic;
        logic [W-1:0] ta[3] = '{8'hFF, 8'h5A, 8'h12};
        logic [W-1:0] tb[3] = '{8'h01, 8'hA5, 8'h34};
        logic         tc[3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   e;
        logic [W-1:0] prev;
        int n, bn;
        bit to;
        for (int k = 0; k < 3; k++) begin
            prev = sum;
            drive_op(ta[k], tb[k], tc[k], 1'b0);
            accept;
            tick; tick; tick;
            n_checks++; if (sum !== prev) begin n_fail++; $display("FAIL basic_hold[%0d] got %h want %h", k, sum, prev); end
            wait_done(n, bn, to);
            n += 3; bn += 3;
            n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout[%0d] got timeout want done", k); end
            n_checks++; if (n != W) begin n_fail++; $display("FAIL basic_latency[%0d] got %0d want %0d", k, n, W); end
            n_checks++; if (bn != W) begin n_fail++; $display("FAIL basic_busy[%0d] got %0d want %0d", k, bn, W); end
            e = exp_q.pop_front();
            n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL basic_result[%0d] got %b_%h want %b_%h", k, cout, sum, e[W], e[W-1:0]); end
`ifdef SERIAL_ADDER_SUB_EN
            void'(ovf_q.pop_front());
`endif
            tick;
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse[%0d] got %b want 0", k, done); end
        end
    endtask

    task automatic test_ignore_start;
        logic [W:0] e;
        int n, bn, extra;
        bit to;
        drive_op(8'hFF, 8'h01, 1'b0, 1'b0);
        accept;
        tick; tick; tick;
        a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(n, bn, to);
        n += 4;
        n_checks++; if (to) begin n_fail++; $display("FAIL ignore_timeout got timeout want done"); end
        n_checks++; if (n != W) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", n, W); end
        e = exp_q.pop_front();
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL ignore_result got %b_%h want %b_%h", cout, sum, e[W], e[W-1:0]); end
`ifdef SERIAL_ADDER_SUB_EN
        void'(ovf_q.pop_front());
`endif
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL ignore_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [W:0] e;
        int n, bn;
        bit to;
        drive_op(8'h33, 8'h11, 1'b0, 1'b0);
        accept;
        wait_done(n, bn, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_first_timeout got timeout want done"); end
        e = exp_q.pop_front();
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL b2b_first got %b_%h want %b_%h", cout, sum, e[W], e[W-1:0]); end
`ifdef SERIAL_ADDER_SUB_EN
        void'(ovf_q.pop_front());
`endif
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done got %b want 1", ready); end
        drive_op(8'h80, 8'h80, 1'b0, 1'b0);
        accept;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap got busy=%b want 1", busy); end
        wait_done(n, bn, to);
        n += 1;
        n_checks++; if (to || n != W + 1) begin n_fail++; $display("FAIL b2b_interval got %0d want %0d", n, W + 1); end
        e = exp_q.pop_front();
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL b2b_second got %b_%h want %b_%h", cout, sum, e[W], e[W-1:0]); end
`ifdef SERIAL_ADDER_SUB_EN
        void'(ovf_q.pop_front());
`endif
        tick;
    endtask

    task automatic test_reset_mid;
        logic [W:0] e;
        int n, bn, cnt_done;
        bit to;
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick; tick;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (sum !== '0 || cout !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs got %b_%h want 0_00", cout, sum); end
        n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got ready=%b busy=%b want 1/0", ready, busy); end
        tick;
        rst_n = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) cnt_done++;
            tick;
        end
        n_checks++; if (cnt_done != 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", cnt_done); end
        drive_op(8'h03, 8'h04, 1'b0, 1'b0);
        accept;
        wait_done(n, bn, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout got timeout want done"); end
        e = exp_q.pop_front();
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL rstmid_after got %b_%h want %b_%h", cout, sum, e[W], e[W-1:0]); end
`ifdef SERIAL_ADDER_SUB_EN
        void'(ovf_q.pop_front());
`endif
        tick;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [W-1:0] ta[3] = '{8'h10, 8'h80, 8'h7F};
        logic [W-1:0] tb[3] = '{8'h01, 8'h01, 8'h80};
        logic [W:0]   e;
        bit           eo;
        int n, bn;
        bit to;
        for (int k = 0; k < 3; k++) begin
            drive_op(ta[k], tb[k], 1'b0, 1'b1);
            accept;
            sub = 1'b0;
            wait_done(n, bn, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL sub_timeout[%0d] got timeout want done", k); end
            e  = exp_q.pop_front();
            eo = ovf_q.pop_front();
            n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL sub_result[%0d] got %b_%h want %b_%h", k, cout, sum, e[W], e[W-1:0]); end
            n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL sub_ovf[%0d] got %b want %b", k, ovf, eo); end
            tick;
        end
    endtask
`endif

    task automatic test_random;
        logic [W:0] e;
        int n, bn;
        bit to;
        for (int k = 0; k < 6; k++) begin
            drive_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            accept;
            wait_done(n, bn, to);
            e = exp_q.pop_front();
            n_checks++; if (to || {cout, sum} !== e) begin n_fail++; $display("FAIL random[%0d] got %b_%h want %b_%h", k, cout, sum, e[W], e[W-1:0]); end
`ifdef SERIAL_ADDER_SUB_EN
            void'(ovf_q.pop_front());
`endif
            tick;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick; tick;
        test_reset;
        rst_n = 1'b1;
        tick;
        test_basic;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add controller that reuses a single one-bit full-adder cell (sum = a^b^c, carry = a&b | (a^b)&c) over WIDTH cycles.
- Latches two WIDTH-bit operands on a start pulse and shifts them LSB-first through the cell, keeping the carry in a flip-flop.
- Publishes the registered sum and carry-out with a one-cycle done pulse.
- Sits between a requesting master and the adder datapath; used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when ready=1.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in; sampled with start.
- ready  output  1  block can accept start (state IDLE or DONE).
- busy  output  1  serial add in progress (state RUN).
- done  output  1  one-cycle pulse; sum/cout updated this cycle.
- sum  output  WIDTH  result of the last completed operation.
- cout  output  1  carry-out of the last completed operation.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0, carry flip-flop=0, shift registers=0.
  - sum=0, cout=0, done=0, busy=0, ready=1.
- FSM has three states:
  - IDLE: on start at edge E0, latch a, b, cin into the shift registers and carry flip-flop, clear the counter, and go to RUN.
  - RUN: each cycle compute one bit from a_sh[0], b_sh[0] and carry. Shift a_sh and b_sh right by one. Shift the sum bit into the MSB of the result shift register. Update the carry flip-flop and increment the counter.
  - RUN exit: when the counter reaches WIDTH-1, at that edge (E0+WIDTH) copy the final result to sum, copy the final carry to cout, and go to DONE.
  - DONE: done=1 and ready=1 for exactly one cycle. With start, behave as IDLE and go to RUN (back-to-back). Without start, go to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH; issue interval is WIDTH+1 cycles.
- busy=1 exactly WIDTH cycles per operation.
- start while busy=1 is ignored: no latch, no queue, no error.
- sum and cout hold their value until the next completion; the internal shift register is not visible on the outputs mid-operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No signed interpretation.
- Reset asserted mid-RUN aborts immediately. sum and cout return to 0 and no done is produced.
- a, b, cin may change freely after the accepting edge.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1: latch ~b into b_sh and force carry flip-flop=1; cin is ignored. The result is a - b with cout=1 meaning no borrow.
  - Adds output ovf (1 bit, reset 0), updated with sum. It is the signed overflow flag: carry into MSB XOR carry out of MSB.
- Undefined: no sub/ovf ports; add-only behaviour as above.

Test Plan:
- WIDTH=8, a=0xFF, b=0x01, cin=0, start in IDLE -> busy high 8 cycles; done in cycle 9 after start; sum=0x00, cout=1.
- a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1. Then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
- Start pulsed again 3 cycles into RUN with a=0x00, b=0x00 -> ignored; the first result (0xFF+0x01 -> 0x00, cout=1) is unaffected and only one done pulse occurs.
- start held during the DONE cycle with a=0x80, b=0x80, cin=0 -> new operation starts with no IDLE gap; second done 9 cycles after the first with sum=0x00, cout=1.
- rst_n low for 1 cycle at RUN bit 4 -> outputs 0 and ready=1 immediately; no done pulse. A following start with a=0x03, b=0x04 gives sum=0x07.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1, ovf=0.
  - sub=1, a=0x80, b=0x01 -> sum=0x7F, ovf=1.
